// File: rtl/md_issue_ctrl.sv
// Issue controller between the E stage and the mul_div unit: launches md ops, writes HI/LO,
// tracks the Busy handshake and stalls HI/LO consumers. Optional MD_PERF_EN adds StallCnt.
module md_issue_ctrl #(
  parameter int unsigned ACK_TIMEOUT = 4
`ifdef MD_PERF_EN
  , parameter int unsigned CNT_W = 16
`endif
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              E_Valid,
  input  logic [2:0]        E_MdOp,
  input  logic [31:0]       E_RsVal,
  input  logic [31:0]       E_RtVal,
  input  logic              D_MdUse,
  input  logic              Busy,
  output logic [31:0]       D1,
  output logic [31:0]       D2,
  output logic [1:0]        Op,
  output logic              Start,
  output logic              We,
  output logic              HiLo,
  output logic              Stall,
  output logic              Err
`ifdef MD_PERF_EN
  , output logic [CNT_W-1:0] StallCnt
`endif
);

  localparam int unsigned ACW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [ACW-1:0] ACK_LIM = ACW'(ACK_TIMEOUT);

  typedef enum logic [1:0] {StIdle, StLaunch, StRun} state_e;

  state_e          state_q, state_d;
  logic [ACW-1:0]  ack_q, ack_d, ack_inc;
  logic [31:0]     d1_q, d1_d, d2_q, d2_d;
  logic [1:0]      op_q, op_d;
  logic            start_q, start_d;
  logic            we_q, we_d;
  logic            hilo_q, hilo_d;
  logic            err_q, err_d;
  logic            is_md, is_mv;

  assign is_md   = E_Valid && (E_MdOp >= 3'd1) && (E_MdOp <= 3'd4);
  assign is_mv   = E_Valid && ((E_MdOp == 3'd5) || (E_MdOp == 3'd6));
  assign ack_inc = ack_q + ACW'(1);

  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
    op_d    = op_q;
    start_d = 1'b0;
    we_d    = 1'b0;
    hilo_d  = hilo_q;
    err_d   = err_q;
    case (state_q)
      StIdle: begin
        if (is_md) begin
          d1_d    = E_RsVal;
          d2_d    = E_RtVal;
          // mult=1,multu=2,div=3,divu=4 map to {is_div, is_signed}
          op_d    = {(E_MdOp >= 3'd3), E_MdOp[0]};
          start_d = 1'b1;
          ack_d   = '0;
          state_d = StLaunch;
        end else if (is_mv) begin
          d1_d   = E_RsVal;
          we_d   = 1'b1;
          hilo_d = (E_MdOp == 3'd5);
        end
      end
      StLaunch: begin
        if (Busy) begin
          ack_d   = '0;
          state_d = StRun;
        end else if (ack_inc == ACK_LIM) begin
          ack_d   = '0;
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          ack_d = ack_inc;
        end
      end
      StRun: begin
        if (!Busy) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Ops arriving while a previous op is in flight are dropped and flagged.
    if ((state_q != StIdle) && (is_md || is_mv)) err_d = 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= StIdle;
      ack_q   <= '0;
      d1_q    <= '0;
      d2_q    <= '0;
      op_q    <= '0;
      start_q <= 1'b0;
      we_q    <= 1'b0;
      hilo_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      op_q    <= op_d;
      start_q <= start_d;
      we_q    <= we_d;
      hilo_q  <= hilo_d;
      err_q   <= err_d;
    end
  end

  assign D1    = d1_q;
  assign D2    = d2_q;
  assign Op    = op_q;
  assign Start = start_q;
  assign We    = we_q;
  assign HiLo  = hilo_q;
  assign Err   = err_q;
  // Busy is honoured even in IDLE so a stale unit after reset still holds consumers.
  assign Stall = D_MdUse && ((state_q != StIdle) || start_q || Busy);

`ifdef MD_PERF_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt_q <= '0;
    end else if (Stall && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign StallCnt = cnt_q;
`endif

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Randomised scoreboard bench for md_issue_ctrl: expected issues and per-cycle Stall/Err are
// derived from busy/launch windows computed per transaction.
module tb_md_issue_ctrl;

  localparam int ACK  = 4;
  localparam int NCYC = 3000;
  localparam int INF  = 32'h7fffffff;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        E_Valid;
  logic [2:0]  E_MdOp;
  logic [31:0] E_RsVal, E_RtVal;
  logic        D_MdUse, Busy;
  logic [31:0] D1, D2;
  logic [1:0]  Op;
  logic        Start, We, HiLo, Stall, Err;
`ifdef MD_PERF_EN
  logic [15:0] StallCnt;
  logic [15:0] m_cnt = '0;
`endif

  md_issue_ctrl #(.ACK_TIMEOUT(ACK)) dut (
    .Clk(Clk), .Rst(Rst), .E_Valid(E_Valid), .E_MdOp(E_MdOp), .E_RsVal(E_RsVal),
    .E_RtVal(E_RtVal), .D_MdUse(D_MdUse), .Busy(Busy), .D1(D1), .D2(D2), .Op(Op),
    .Start(Start), .We(We), .HiLo(HiLo), .Stall(Stall), .Err(Err)
`ifdef MD_PERF_EN
    , .StallCnt(StallCnt)
`endif
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int          cyc;
    bit          we;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [1:0]  op;
    bit          hilo;
  } ev_t;

  typedef struct {
    int cyc;
    bit stall;
    bit err;
    bit rst_chk;
  } cy_t;

  ev_t evq[$];
  cy_t cyq[$];
  int  cyc    = 0;
  int  n_vec  = 0;
  int  n_fail = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [1:0] op_code(input int mdop);
    case (mdop)
      1:       return 2'd1;  // mult
      2:       return 2'd0;  // multu
      3:       return 2'd3;  // div
      default: return 2'd2;  // divu
    endcase
  endfunction

  // Monitor: pops per-cycle expectations and issue events as the DUT presents them.
  cy_t r;
  ev_t e;
  always @(negedge Clk) begin
    if (cyq.size() > 0) begin
      r = cyq.pop_front();
      check("stall", Stall, r.stall);
      check("err", Err, r.err);
      if (r.rst_chk) begin
        check("rst_d1", D1, 0);
        check("rst_d2", D2, 0);
        check("rst_op", Op, 0);
        check("rst_start", Start, 0);
        check("rst_we", We, 0);
        check("rst_hilo", HiLo, 0);
      end
`ifdef MD_PERF_EN
      if (r.rst_chk) m_cnt = '0;
      check("stallcnt", StallCnt, m_cnt);
      if (r.stall && m_cnt != 16'hffff) m_cnt = m_cnt + 16'd1;
`endif
    end
    while (evq.size() > 0 && evq[0].cyc < cyc) begin
      e = evq.pop_front();
      n_vec++;
      n_fail++;
      $display("FAIL missing_issue: got none, want %s at cycle %0d", e.we ? "We" : "Start", e.cyc);
    end
    if (Start || We) begin
      check("start_we_excl", Start & We, 0);
      if (evq.size() == 0 || evq[0].cyc != cyc) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_issue at cycle %0d: got Start=%0b We=%0b, want none",
                 cyc, Start, We);
      end else begin
        e = evq.pop_front();
        check("start", Start, !e.we);
        check("we", We, e.we);
        check("d1", D1, e.d1);
        if (e.we) check("hilo", HiLo, e.hilo);
        else begin
          check("d2", D2, e.d2);
          check("op", Op, e.op);
        end
      end
    end
  end

  // Driver + reference model: each launched op owns a non-idle window and a Busy window.
  initial begin
    int c, d, l, ni_lo, ni_hi, b_lo, b_hi, err_from, op;
    bit idle, in_busy, can_issue, do_rst, rst_prev;
    cy_t cr;
    ev_t ev;
    Rst = 1'b1; E_Valid = 1'b0; E_MdOp = '0; E_RsVal = '0; E_RtVal = '0;
    D_MdUse = 1'b0; Busy = 1'b0;
    ni_lo = 1; ni_hi = 0; b_lo = 1; b_hi = 0; err_from = INF; rst_prev = 1'b1;
    repeat (2) @(posedge Clk);
    for (int i = 0; i < NCYC; i++) begin
      #1;
      c         = cyc;
      idle      = !(c >= ni_lo && c <= ni_hi);
      in_busy   = (c >= b_lo && c <= b_hi);
      can_issue = idle && (c > b_hi) && (i < NCYC - 10);
      do_rst    = (i > 5) && (i < NCYC - 10) && ($urandom_range(0, 49) == 0);
      Busy      = in_busy || (can_issue && $urandom_range(0, 7) == 0);
      D_MdUse   = 1'($urandom_range(0, 1));
      E_MdOp    = 3'($urandom_range(0, 7));
      E_RsVal   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      E_RtVal   = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFC : $urandom;
      Rst       = do_rst;
      E_Valid   = 1'b0;
      if (!do_rst && i < NCYC - 10) begin
        if (can_issue)  E_Valid = ($urandom_range(0, 2) != 0);
        else if (!idle) E_Valid = ($urandom_range(0, 15) == 0);
      end
      op = int'(E_MdOp);
      cr.cyc = c;
      cr.stall = D_MdUse && (!idle || Busy);
      cr.err = (c >= err_from);
      cr.rst_chk = rst_prev;
      cyq.push_back(cr);
      if (E_Valid && op >= 1 && op <= 6) begin
        if (!idle) begin
          if (c + 1 < err_from) err_from = c + 1;
        end else if (op <= 4) begin
          d = $urandom_range(0, 5);
          l = $urandom_range(1, 6);
          ev.cyc = c + 1; ev.we = 1'b0; ev.d1 = E_RsVal; ev.d2 = E_RtVal;
          ev.op = op_code(op); ev.hilo = 1'b0;
          evq.push_back(ev);
          ni_lo = c + 1;
          if (d < ACK) begin
            b_lo  = c + 1 + d;
            b_hi  = c + d + l;
            ni_hi = c + d + l + 1;
          end else begin
            ni_hi = c + ACK;
            if (c + ACK + 1 < err_from) err_from = c + ACK + 1;
          end
        end else begin
          ev.cyc = c + 1; ev.we = 1'b1; ev.d1 = E_RsVal; ev.d2 = '0;
          ev.op = '0; ev.hilo = (op == 5);
          evq.push_back(ev);
        end
      end
      if (do_rst) begin
        if (ni_hi > c) ni_hi = c;
        err_from = INF;
      end
      rst_prev = do_rst;
      @(posedge Clk);
    end
    #1;
    Rst = 1'b0; E_Valid = 1'b0; Busy = 1'b0;
    @(negedge Clk);
    check("pending_events", evq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
